execute_pipe: RTL
=================

// Module: execute_pipe
// PURPOSE
//  Registered, parametrised execute stage for the WISC pipeline. It takes decoded
//  operands from decode and computes the ALU result with cond-set post-processing.
//  It resolves branches on Reg1 and produces a taken flag plus the branch target.
//  The result goes to memory/writeback behind a valid/ready handshake. Unlike the
//  single-cycle stage, it has an output register, backpressure, flush, and an
//  optional multi-cycle multiplier.
// PARAMETERS
//  WIDTH     16   datapath width (operands, immediate, PC, result); >= 4
//  MUL_STEPS 16   multiplier iterations; must equal WIDTH
// PORTS
//  Clk          in   1      clock; all state updates on rising edge
//  Rst          in   1      synchronous active-high reset
//  Flush        in   1      kill in-flight and held op (mispredict/exception)
//  InValid      in   1      decode presents an op
//  InReady      out  1      stage can accept; accept = InValid & InReady
//  Reg1, Reg2   in   WIDTH  register operands
//  Imm, Pc      in   WIDTH  sign-extended immediate; PC of this instr + 2
//  AluSrc       in   1      1: B = Imm, 0: B = Reg2
//  AluOp        in   4      0 ADD,1 SUB(A-B),2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 ROL,9 PASSB,10 MUL
//  CondOp       in   3      0 none,1 SEQ,2 SLT,3 SLE,4 SCO(carry of A+B); 5-7 as 0
//  BranchCode   in   3      [2] branch enable; [1:0] 0 BEQZ,1 BNEZ,2 BLTZ,3 BGEZ on Reg1
//  OutValid     out  1      Output/PcSrc/BranchTarget valid
//  OutReady     in   1      consumer takes; transfer = OutValid & OutReady
//  Output       out  WIDTH  result (ALU or cond-set 0/1, zero-extended)
//  PcSrc        out  1      branch taken (qualified by OutValid)
//  BranchTarget out  WIDTH  Pc + Imm, WIDTH-bit wrap
// BEHAVIOUR
//  - Reset: OutValid=0, PcSrc=0, Output=0, BranchTarget=0, FSM=IDLE, InReady=1.
//  - FSM states:
//    - IDLE: output register empty.
//    - FULL: result held.
//    - MUL: iterating.
//  - InReady = (IDLE | (FULL & OutReady)) & ~Flush; never 1 in MUL.
//  - Single-cycle op accepted at edge N: result registered at N, OutValid=1 from N.
//    Latency is 1 cycle, and throughput is 1 op/cycle when OutReady stays high.
//  - FULL holds all outputs stable while OutReady=0.
//    - On transfer with no new accept, go to IDLE.
//    - On transfer plus accept, stay FULL with the new result.
//  - Arithmetic is two's complement mod 2^WIDTH.
//  - Shift amount is B[$clog2(WIDTH)-1:0]; SRA replicates sign; ROL rotates left.
//  - SLT/SLE use the signed compare, corrected for overflow:
//    lt = sign(A-B) ^ ofl(A-B); SLE = lt | (A==B).
//  - SCO uses the carry-out of the unsigned A+B.
//  - Branch: PcSrc = BranchCode[2] & cond(Reg1); conditions are Reg1==0, !=0, <0, >=0.
//    Output still carries the ALU/cond result for branches.
//  - MUL accept goes to MUL with an iteration counter = 0.
//    - One shift-add step per cycle for MUL_STEPS cycles, then FULL.
//    - OutValid stays 0 during MUL; the result is the low WIDTH bits of A*B (unsigned).
//    - Latency is MUL_STEPS+1 edges from accept to OutValid.
//  - Flush (highest priority after Rst) drops the MUL or FULL contents and goes to IDLE
//    at that edge. OutValid=0 and PcSrc=0 next cycle; no accept that cycle.
//  - Rst mid-MUL aborts the multiply; Rst wins over Flush/accept/transfer the same edge.
//  - OutReady with OutValid=0 is ignored.
// CONFIGURATION
//  - EXEC_MUL_EN defined: AluOp 10 runs the iterative multiplier and the MUL state exists.
//  - EXEC_MUL_EN undefined: no MUL state or counter. AluOp 10 is a single-cycle op giving
//    Output=0, PcSrc evaluated normally; AluOp 11-15 give 0 in both builds.
// TESTING
//  1. Rst=1 for 2 cycles, mid-stream -> OutValid=0, PcSrc=0, InReady=1 next cycle.
//  2. WIDTH=16: ADD 0x7FFF+0x0001 CondOp=0 -> Output=0x8000.
//     SLT 0x8000,0x0001 -> 1. SCO 0xFFFF+1 -> 1. All one cycle after accept.
//  3. BEQZ Reg1=0, Pc=0x0010, Imm=0xFFF0 -> PcSrc=1, BranchTarget=0x0000.
//     BNEZ Reg1=0 -> PcSrc=0.
//  4. Hold OutReady=0 with 3 back-to-back ops -> first result held stable, InReady=0.
//     Release -> results delivered in order, none lost or duplicated.
//  5. EXEC_MUL_EN: MUL 0x0012*0x0034 -> InReady=0 for 16 cycles, then Output=0x03A8.
//     Repeat with Flush at step 5 -> IDLE, no OutValid.
//  6. Without EXEC_MUL_EN: MUL 3*4 -> Output=0 after 1 cycle.

Source files
------------

// File: rtl/execute_pipe.sv
// Registered WISC execute stage: ALU with cond-set, branch resolve, valid/ready output register.
// Define EXEC_MUL_EN to make AluOp 10 run the iterative shift-add multiplier.
module execute_pipe #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Reg1,
    input  logic [WIDTH-1:0] Reg2,
    input  logic [WIDTH-1:0] Imm,
    input  logic [WIDTH-1:0] Pc,
    input  logic             AluSrc,
    input  logic [3:0]       AluOp,
    input  logic [2:0]       CondOp,
    input  logic [2:0]       BranchCode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Output,
    output logic             PcSrc,
    output logic [WIDTH-1:0] BranchTarget
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FULL = 2'd1;
`ifdef EXEC_MUL_EN
    localparam logic [1:0] MUL  = 2'd2;
    localparam int CW = $clog2(MUL_STEPS);
    localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);
`endif

    if (MUL_STEPS != WIDTH) begin : g_steps_check
        $error("execute_pipe: MUL_STEPS must equal WIDTH");
    end

    function automatic logic [WIDTH-1:0] alu(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b,
                                             input logic [3:0] op);
        logic [SW-1:0]      sh;
        logic [2*WIDTH-1:0] rot;
        sh  = b[SW-1:0];
        // Rotate by shifting a doubled copy and keeping the upper half.
        rot = {a, a} << sh;
        case (op)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = a << sh;
            4'd6:    alu = $unsigned(a) >> sh;
            4'd7:    alu = a >>> sh;
            4'd8:    alu = rot[2*WIDTH-1:WIDTH];
            4'd9:    alu = b;
            default: alu = '0;
        endcase
    endfunction

    function automatic logic cond_flag(input logic signed [WIDTH-1:0] a,
                                       input logic signed [WIDTH-1:0] b,
                                       input logic [2:0] op);
        logic signed [WIDTH-1:0] diff;
        logic [WIDTH:0]          sum;
        logic                    ofl;
        logic                    lt;
        diff = a - b;
        ofl  = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
        lt   = diff[WIDTH-1] ^ ofl;
        sum  = {1'b0, a} + {1'b0, b};
        case (op)
            3'd1:    cond_flag = (a == b);
            3'd2:    cond_flag = lt;
            3'd3:    cond_flag = lt | (a == b);
            3'd4:    cond_flag = sum[WIDTH];
            default: cond_flag = 1'b0;
        endcase
    endfunction

    logic [1:0]              state;
    logic                    taken_p1;
    logic signed [WIDTH-1:0] a_p0;
    logic signed [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0]        res_p0;
    logic [WIDTH-1:0]        tgt_p0;
    logic                    taken_p0;
    logic                    cond_en_p0;
    logic                    accept;

    // Stage p0: combinational operand select, ALU, cond-set and branch resolve.
    always_comb begin
        a_p0       = Reg1;
        b_p0       = AluSrc ? Imm : Reg2;
        cond_en_p0 = (CondOp != 3'd0) && (CondOp <= 3'd4);
        res_p0     = cond_en_p0 ? {{(WIDTH-1){1'b0}}, cond_flag(a_p0, b_p0, CondOp)}
                                : alu(a_p0, b_p0, AluOp);
        tgt_p0     = Pc + Imm;
        case (BranchCode[1:0])
            2'd0:    taken_p0 = (Reg1 == '0);
            2'd1:    taken_p0 = (Reg1 != '0);
            2'd2:    taken_p0 = Reg1[WIDTH-1];
            default: taken_p0 = ~Reg1[WIDTH-1];
        endcase
        taken_p0 = taken_p0 & BranchCode[2];
    end

    assign InReady  = ((state == IDLE) | ((state == FULL) & OutReady)) & ~Flush;
    assign accept   = InValid & InReady;
    assign OutValid = (state == FULL);
    assign PcSrc    = taken_p1 & OutValid;

`ifdef EXEC_MUL_EN
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;
    logic             start_mul;

    assign start_mul = (AluOp == 4'd10);
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    // Multiplier datapath: one shift-add step per cycle while in MUL; cond-set does not apply.
    always_ff @(posedge Clk) begin
        if (accept && start_mul) begin
            acc    <= '0;
            mcand  <= a_p0;
            mplier <= b_p0;
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`endif

    // Stage p1: output register and control FSM.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            taken_p1     <= 1'b0;
            Output       <= '0;
            BranchTarget <= '0;
`ifdef EXEC_MUL_EN
            cnt          <= '0;
`endif
        end else if (Flush) begin
            state <= IDLE;
        end else if (accept) begin
            Output       <= res_p0;
            BranchTarget <= tgt_p0;
            taken_p1     <= taken_p0;
`ifdef EXEC_MUL_EN
            if (start_mul) begin
                state <= MUL;
                cnt   <= '0;
            end else begin
                state <= FULL;
            end
`else
            state <= FULL;
`endif
        end else if (state == FULL) begin
            if (OutReady) state <= IDLE;
        end
`ifdef EXEC_MUL_EN
        else if (state == MUL) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state  <= FULL;
                Output <= acc_next;
            end
        end
`endif
    end

endmodule
